// File: rtl/mem_port_arbiter.sv
// Four-way arbiter for the single physical-memory port: one line transaction per grant.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (slot 0 highest).
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             req_read,
  input  logic [3:0]             req_write,
  input  logic [3:0][ADDR_W-1:0] req_addr,
  input  logic [3:0][LINE_W-1:0] req_wdata,
  output logic [3:0]             req_resp,
  output logic [LINE_W-1:0]      req_rdata,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   mem_resp,
  output logic [1:0]             grant_idx,
  output logic                   grant_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] pending;
  logic [1:0] search_base;
  logic [1:0] cand;
  logic [1:0] winner;
  logic       found;

`ifdef ARB_FIXED_PRIO_EN
  assign search_base = 2'd0;
`else
  logic [1:0] rr_ptr;
  assign search_base = rr_ptr;
`endif

  assign pending = req_read | req_write;

  // Scan the four slots starting at search_base; 2-bit addition wraps 3 -> 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    winner = search_base;
    found  = 1'b0;
    cand   = search_base;
    for (int k = 0; k < 4; k++) begin
      cand = search_base + 2'(k);
      if (!found && pending[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Address and data follow the live inputs of the owning slot.
  assign mem_addr  = req_addr[grant_idx];
  assign mem_wdata = req_wdata[grant_idx];
  assign req_rdata = mem_rdata;

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    req_resp  = 4'b0000;
    case (state)
      IDLE: begin
        if (found) state_nxt = BUSY;
      end
      BUSY: begin
        mem_write = req_write[grant_idx];
        mem_read  = req_read[grant_idx] & ~req_write[grant_idx];
        if (mem_resp) begin
          req_resp[grant_idx] = 1'b1;
          state_nxt           = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr      <= 2'd0;
`endif
    end else begin
      state       <= state_nxt;
      grant_valid <= (state_nxt == BUSY);
      if (state == IDLE && found) grant_idx <= winner;
`ifndef ARB_FIXED_PRIO_EN
      if (state == BUSY && mem_resp) rr_ptr <= grant_idx + 2'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req_read;
  logic [3:0]         req_write;
  logic [3:0][AW-1:0] req_addr;
  logic [3:0][LW-1:0] req_wdata;
  logic [3:0]         req_resp;
  logic [LW-1:0]      req_rdata;
  logic               mem_read;
  logic               mem_write;
  logic [AW-1:0]      mem_addr;
  logic [LW-1:0]      mem_wdata;
  logic [LW-1:0]      mem_rdata;
  logic               mem_resp;
  logic [1:0]         grant_idx;
  logic               grant_valid;

  int total = 0;
  int bad   = 0;
  int ptr   = 0;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_resp(req_resp), .req_rdata(req_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .grant_idx(grant_idx), .grant_valid(grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: first requesting slot found walking start, start+1, ... modulo 4.
  function automatic int pick(input logic [3:0] p, input int start);
    for (int k = 0; k < 4; k++)
      if (p[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic post(input int s, input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [LW-1:0] d);
    req_read[s]  = rd;
    req_write[s] = wr;
    req_addr[s]  = a;
    req_wdata[s] = d;
  endtask

  task automatic post_rand(input int s);
    int op;
    op = $urandom_range(0, 2);
    post(s, op != 1, op != 0, AW'($urandom()), rnd_line());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered during an IDLE cycle with requests already driven; returns at the
  // sampling point of the IDLE cycle that follows RELEASE.
  task automatic run_txn(input int delay, input bit rereq, input logic [3:0] add_mask,
                         input logic [LW-1:0] rd);
    int         w;
    logic [3:0] pend;
    logic [3:0] exp_resp;
    bit         exp_wr;
    bit         exp_rd;
    pend = req_read | req_write;
    w    = pick(pend, ptr);
    if (w < 0) return;
    exp_wr   = req_write[w];
    exp_rd   = req_read[w] & ~req_write[w];
    exp_resp = 4'b0001 << w;
    step();
    for (int s = 0; s < 4; s++)
      if (add_mask[s] && !pend[s]) post_rand(s);
    @(negedge clk);
    check("grant_valid", LW'(grant_valid), LW'(1'b1));
    check("grant_idx", LW'(grant_idx), LW'(w));
    check("mem_write", LW'(mem_write), LW'(exp_wr));
    check("mem_read", LW'(mem_read), LW'(exp_rd));
    check("mem_addr", LW'(mem_addr), LW'(req_addr[w]));
    if (exp_wr) check("mem_wdata", mem_wdata, req_wdata[w]);
    check("resp_early", LW'(req_resp), '0);
    repeat (delay) begin
      step();
      @(negedge clk);
      check("busy_hold", LW'({grant_valid, req_resp}), LW'(5'b10000));
    end
    step();
    mem_resp  = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    check("req_resp", LW'(req_resp), LW'(exp_resp));
    check("req_rdata", req_rdata, rd);
    step();
    mem_resp     = 1'b0;
    req_read[w]  = 1'b0;
    req_write[w] = 1'b0;
    @(negedge clk);
    check("release", LW'({grant_valid, mem_read, mem_write, req_resp}), '0);
`ifndef ARB_FIXED_PRIO_EN
    ptr = (w + 1) % 4;
`endif
    step();
    if (rereq) post(w, 1'b1, 1'b0, AW'($urandom()), rnd_line());
    @(negedge clk);
    check("idle_gap", LW'({grant_valid, mem_read, mem_write}), '0);
  endtask

  initial begin
    logic [3:0] m;
    bit         first;
    rst_n     = 1'b0;
    req_read  = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_rdata = '0;
    mem_resp  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_outputs", LW'({grant_valid, grant_idx, mem_read, mem_write, req_resp}), '0);

    // Stray memory response while idle.
    step();
    mem_resp = 1'b1;
    @(negedge clk);
    check("stray_resp", LW'({grant_valid, req_resp}), '0);
    step();
    mem_resp = 1'b0;
    @(negedge clk);
    check("stray_idle", LW'({grant_valid, mem_read, mem_write}), '0);

    // Single read from slot 1.
    post(1, 1'b1, 1'b0, 16'h1230, '0);
    run_txn(5, 1'b0, 4'b0000, {16{8'hA5}});

    // Reset while slot 1 is outstanding, then a late response.
    post(1, 1'b1, 1'b0, 16'h0440, '0);
    step();
    @(negedge clk);
    check("pre_rst_grant", LW'({grant_valid, grant_idx}), LW'(3'b101));
    rst_n = 1'b0;
    step();
    rst_n       = 1'b1;
    mem_resp    = 1'b1;
    req_read[1] = 1'b0;
    ptr         = 0;
    @(negedge clk);
    check("mid_rst", LW'({grant_valid, grant_idx, mem_read, mem_write, req_resp}), '0);
    step();
    mem_resp = 1'b0;
    @(negedge clk);
    check("post_rst_idle", LW'({grant_valid, req_resp}), '0);

    // Contention: all four at once; the first winner re-requests immediately.
    for (int s = 0; s < 4; s++) post(s, 1'b1, 1'b0, AW'($urandom()), rnd_line());
    first = 1'b1;
    while ((req_read | req_write) != 4'b0000) begin
      run_txn($urandom_range(0, 2), first, 4'b0000, rnd_line());
      first = 1'b0;
    end

    // Wrap: slot 3 served while 0 and 2 arrive.
    post(3, 1'b0, 1'b1, AW'($urandom()), rnd_line());
    run_txn(1, 1'b0, 4'b0101, rnd_line());
    while ((req_read | req_write) != 4'b0000)
      run_txn(0, 1'b0, 4'b0000, rnd_line());

    // Read and write together on slot 2: write wins.
    post(2, 1'b1, 1'b1, 16'h2000, {16{8'h0F}});
    run_txn(2, 1'b0, 4'b0000, rnd_line());

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ((req_read | req_write) == 4'b0000) begin
        repeat ($urandom_range(0, 2)) begin
          step();
          @(negedge clk);
          check("idle_wait", LW'({grant_valid, req_resp}), '0);
        end
        m = 4'($urandom_range(1, 15));
        for (int s = 0; s < 4; s++) if (m[s]) post_rand(s);
      end
      run_txn($urandom_range(0, 4), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              rnd_line());
    end
    while ((req_read | req_write) != 4'b0000)
      run_txn(0, 1'b0, 4'b0000, rnd_line());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single physical-memory port among four cache-side requesters (slot 0 I-cache, 1 D-cache, 2 write-back buffer, 3 prefetcher).
- Round-robin arbitration; one whole line transaction per grant.
- The registered 2-bit grant index drives the way/port decoder that steers responses.
- Sits between the cache controllers and main memory.

## Interface
Parameters:
- ADDR_W, 16, memory address width (byte address of line)
- LINE_W, 128, cache line width in bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- req_read  in  4  per-slot line read request, level, held until that slot's req_resp
- req_write  in  4  per-slot line write request, level, held until that slot's req_resp
- req_addr  in  4 x ADDR_W  per-slot line address
- req_wdata  in  4 x LINE_W  per-slot write data
- req_resp  out  4  per-slot completion pulse, one-hot or zero
- req_rdata  out  LINE_W  read data, broadcast to all slots
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data
- mem_resp  in  1  memory completion, one-cycle pulse
- grant_idx  out  2  index of owning slot, registered
- grant_valid  out  1  high while a slot owns the port

## Operation
State machine: IDLE, BUSY, RELEASE.

IDLE
- A slot is requesting when req_read[i] or req_write[i] is high.
- If any slot requests, choose the winner by round-robin starting at rr_ptr, searching rr_ptr, rr_ptr+1, ... mod 4.
- Register grant_idx = winner, set grant_valid = 1, go to BUSY.
- With no requests, stay in IDLE.

BUSY
- mem_addr and mem_wdata are muxed combinationally from the live inputs of slot grant_idx.
- mem_write = req_write[grant_idx].
- mem_read = req_read[grant_idx] & ~req_write[grant_idx]; if both are asserted, write wins.
- On mem_resp: req_resp[grant_idx] = 1 in the same cycle; set rr_ptr = grant_idx + 1 (wrap 3 -> 0); go to RELEASE.

RELEASE
- Exactly one cycle. No commands, grant_valid = 0, go to IDLE.
- Gives the requester a cycle to drop its request.

Data and fixed rules
- req_rdata = mem_rdata at all times (pass-through).
- Outside BUSY: mem_read = mem_write = 0, req_resp = 0.
- mem_resp outside BUSY is ignored.
- A slot dropping its request mid-BUSY is a protocol error. The arbiter stays in BUSY until mem_resp; commands follow the live inputs.
- Requests arriving during BUSY or RELEASE wait. No preemption.

## Timing
- Reset (rst_n low at an edge) forces all of the following, including mid-transaction:
  - state = IDLE
  - rr_ptr = 0, grant_idx = 0, grant_valid = 0
  - mem_read = mem_write = 0, req_resp = 0
- Grant latency: a request seen in IDLE at edge N gives grant_valid and the memory command from cycle N+1.
- Response path is combinational: mem_resp to req_resp, mem_rdata to req_rdata.
- Turnaround: mem_resp cycle, then RELEASE, then IDLE, then next BUSY. Minimum of 2 command-free cycles between transactions.
- Fairness: with all four slots continuously requesting, grants rotate 0,1,2,3,0 after reset.

## Configuration
- ARB_FIXED_PRIO_EN defined:
  - Round-robin is replaced by fixed priority: slot 0 highest, slot 3 lowest.
  - rr_ptr is not implemented; the search always starts at 0.
- Not defined: round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Single read: slot 1 reads addr 0x1230; memory responds after 5 cycles with rdata 0xA5..A5. Required: grant_idx = 1 and mem_read high from the next cycle; req_resp = 4'b0010 in the resp cycle; req_rdata = 0xA5..A5; RELEASE cycle follows.
- Contention: all four slots request at once after reset. Required: grants in order 0,1,2,3; each req_resp is one cycle; no overlap of commands. Under ARB_FIXED_PRIO_EN, with slot 0 re-requesting, slot 0 is granted again ahead of 1.
- Read+write on one slot: slot 2 asserts both with wdata 0x0F..0F. Required: mem_write = 1, mem_read = 0, mem_wdata = 0x0F..0F.
- Wrap: slot 3 is served while slot 0 and slot 2 are waiting. Required: slot 0 is granted next (rr_ptr wraps to 0).
- Reset mid-BUSY: rst_n is low for one edge while slot 1 is outstanding. Required: mem_read = 0, grant_valid = 0 next cycle, rr_ptr = 0; a late mem_resp produces no req_resp.
- Stray mem_resp in IDLE: required req_resp = 0 and no state change.
